prio_decoder_seq: RTL and testbench

Sequential counterpart of the 4-to-2 priority encoder. It accepts encoded indices over a valid/ready interface and buffers them in a small FIFO. It then replays each index as a one-hot grant held for a programmable number of cycles. It sits downstream of the encoder and drives per-lane enables or strobes back into the request side.

---
 rtl/prio_decoder_seq.sv | 131 +++++++++++++
 tb/tb_prio_decoder_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/prio_decoder_seq.sv
// Buffers encoded indices with per-entry hold lengths in a small FIFO and
// replays each as a registered one-hot grant, separated by one idle cycle.
module prio_decoder_seq #(
  parameter int IDX_W  = 2,
  parameter int HOLD_W = 4,
  parameter int DEPTH  = 4,
  localparam int N     = 1 << IDX_W,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [HOLD_W-1:0] in_hold,
  output logic [N-1:0]      out_onehot,
  output logic [IDX_W-1:0]  out_idx,
  output logic              busy,
  output logic [LVL_W-1:0]  level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = IDX_W + HOLD_W;

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_e;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]        onehot_q, onehot_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [ENT_W-1:0]    mem_q [DEPTH];

  logic                full, empty, push, pop;
  logic [HOLD_W-1:0]   hold_eff;
  logic [IDX_W-1:0]    head_idx;
  logic [HOLD_W-1:0]   head_hold;

  assign full      = (level_q == LVL_W'(DEPTH));
  assign empty     = (level_q == '0);
  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign hold_eff  = (in_hold == '0) ? HOLD_W'(1) : in_hold;
  assign {head_idx, head_hold} = mem_q[rd_ptr_q];

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case/if tree leaves it unassigned and infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    onehot_d = onehot_q;
    idx_d    = idx_q;
    pop      = 1'b0;
    unique case (state_q)
      IDLE, GAP: begin
        if (!empty) begin
          pop      = 1'b1;
          onehot_d = N'(1) << head_idx;
          idx_d    = head_idx;
          cnt_d    = head_hold;
          state_d  = ACTIVE;
        end else begin
          onehot_d = '0;
          idx_d    = '0;
          state_d  = IDLE;
        end
      end
      ACTIVE: begin
        if (cnt_q == HOLD_W'(1)) begin
          onehot_d = '0;
          idx_d    = '0;
          state_d  = GAP;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      default: begin
        onehot_d = '0;
        idx_d    = '0;
        state_d  = IDLE;
      end
    endcase
  end

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      onehot_q <= '0;
      idx_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
      idx_q    <= idx_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; entries are only
  // read once the pointers and level say they were written.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= {in_idx, hold_eff};
  end

  assign out_onehot = onehot_q;
  assign out_idx    = idx_q;
  assign level      = level_q;
  assign busy       = (state_q != IDLE) || (level_q != '0);

endmodule

// File: tb/tb_prio_decoder_seq.sv
// Directed bench for prio_decoder_seq: reset, single and back-to-back grants,
// backpressure with pointer wrap, push/pop in GAP, and reset mid-grant.
module tb_prio_decoder_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_idx;
  logic [3:0] in_hold;
  logic [3:0] out_onehot;
  logic [1:0] out_idx;
  logic       busy;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  prio_decoder_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_idx     (in_idx),
    .in_hold    (in_hold),
    .out_onehot (out_onehot),
    .out_idx    (out_idx),
    .busy       (busy),
    .level      (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one edge; sampling happens 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] idx, input logic [3:0] hold);
    check("push_ready", in_ready, 1);
    in_valid = 1'b1;
    in_idx   = idx;
    in_hold  = hold;
    step();
    in_valid = 1'b0;
  endtask

  logic [3:0] exp_b2b   [6]  = '{4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
  logic [3:0] exp_drain [12] = '{4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0010,
                                 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_idx = 2'd1; in_hold = 4'd2;
    #1;
    // Reset held two cycles with in_valid high: nothing is accepted.
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_level", level, 0);
      check("rst_ready", in_ready, 1);
      check("rst_onehot", out_onehot, 0);
      check("rst_busy", busy, 0);
    end
    rst = 1'b0; in_valid = 1'b0;
    step();
    check("post_rst_level", level, 0);
    check("post_rst_onehot", out_onehot, 0);

    // Single grant idx=2 hold=3.
    push(2'd2, 4'd3);
    check("single_level_k", level, 1);
    check("single_onehot_k", out_onehot, 0);
    check("single_busy_k", busy, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("single_onehot", out_onehot, 4'b0100);
      check("single_idx", out_idx, 2);
    end
    check("single_level_drained", level, 0);
    step();
    check("single_gap_onehot", out_onehot, 0);
    check("single_gap_idx", out_idx, 0);
    check("single_gap_busy", busy, 1);
    step();
    check("single_busy_fall", busy, 0);

    // Back-to-back with a zero hold treated as one.
    push(2'd3, 4'd1);
    push(2'd0, 4'd0);
    check("b2b_first", out_onehot, 4'b1000);
    push(2'd1, 4'd2);
    check("b2b_gap0", out_onehot, 4'b0000);
    check("b2b_level", level, 2);
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("b2b_seq%0d", i), out_onehot, exp_b2b[i]);
    end
    check("b2b_busy_end", busy, 0);

    // Backpressure: long grant, fill FIFO, hold a fifth request pending.
    push(2'd1, 4'd15);
    push(2'd2, 4'd1);
    push(2'd3, 4'd2);
    push(2'd0, 4'd1);
    push(2'd1, 4'd1);
    check("full_level", level, 4);
    check("full_ready", in_ready, 0);
    in_valid = 1'b1; in_idx = 2'd2; in_hold = 4'd3;
    for (int i = 0; i < 11; i++) step();
    check("full_long_grant", out_onehot, 4'b0010);
    check("full_hold_level", level, 4);
    check("full_hold_ready", in_ready, 0);
    step();
    check("full_gap_onehot", out_onehot, 0);
    check("full_gap_level", level, 4);
    step();
    check("full_pop_onehot", out_onehot, 4'b0100);
    check("full_pop_level", level, 3);
    check("full_pop_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("full_refill_level", level, 4);
    check("full_refill_onehot", out_onehot, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("drain_seq%0d", i), out_onehot, exp_drain[i]);
    end
    check("drain_busy_end", busy, 0);
    check("drain_level_end", level, 0);

    // Simultaneous push and pop while in GAP with one entry queued.
    push(2'd0, 4'd1);
    push(2'd2, 4'd1);
    check("gp_grant0", out_onehot, 4'b0001);
    check("gp_level1", level, 1);
    step();
    check("gp_in_gap", out_onehot, 0);
    check("gp_gap_level", level, 1);
    push(2'd3, 4'd2);
    check("gp_level_same", level, 1);
    check("gp_next_grant", out_onehot, 4'b0100);
    step();
    check("gp_gap2", out_onehot, 0);
    step();
    check("gp_last_a", out_onehot, 4'b1000);
    step();
    check("gp_last_b", out_onehot, 4'b1000);
    step();
    step();
    check("gp_busy_end", busy, 0);

    // Reset in the middle of a grant with two entries queued.
    push(2'd1, 4'd4);
    push(2'd2, 4'd1);
    push(2'd3, 4'd1);
    check("mid_pre_onehot", out_onehot, 4'b0010);
    check("mid_pre_level", level, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_onehot", out_onehot, 0);
    check("mid_rst_idx", out_idx, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_busy", busy, 0);
    step();
    check("mid_no_residual", out_onehot, 0);
    push(2'd3, 4'd1);
    check("mid_latency0", out_onehot, 0);
    step();
    check("mid_new_grant", out_onehot, 4'b1000);
    check("mid_new_idx", out_idx, 3);
    step();
    check("mid_new_end", out_onehot, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
